// File: rtl/ibex_register_file_sram_prefetch_if.sv
// ---------------------------------------------------------------------------
// ibex_register_file_sram_prefetch_if
//   Bundles the prefetch, ID read and WB write signals of the SRAM-backed
//   register file.
//   master : IF/ID/WB side. It drives the prefetched instruction, the read
//            requests and addresses, and the write port. It receives the
//            operand data, the stall flag and the stall counter.
//   slave  : register file side, with the opposite directions.
// ---------------------------------------------------------------------------
interface ibex_register_file_sram_prefetch_if #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned StallCntW = 16
);
    logic [31:0]           pref_instr;
    logic                  instr_new;
    logic                  rd_req_a;
    logic [4:0]            raddr_a;
    logic [DataWidth-1:0]  rdata_a;
    logic                  rd_req_b;
    logic [4:0]            raddr_b;
    logic [DataWidth-1:0]  rdata_b;
    logic                  we;
    logic [4:0]            waddr;
    logic [DataWidth-1:0]  wdata;
    logic                  reg_stall;
    logic [StallCntW-1:0]  stall_cnt;

    modport master (
        output pref_instr, instr_new, rd_req_a, raddr_a, rd_req_b, raddr_b,
               we, waddr, wdata,
        input  rdata_a, rdata_b, reg_stall, stall_cnt
    );

    modport slave (
        input  pref_instr, instr_new, rd_req_a, raddr_a, rd_req_b, raddr_b,
               we, waddr, wdata,
        output rdata_a, rdata_b, reg_stall, stall_cnt
    );
endinterface

// File: rtl/ibex_register_file_sram_prefetch.sv
// ---------------------------------------------------------------------------
// ibex_register_file_sram_prefetch
//   Integer register file for the ID stage. It is built on a 2-port SRAM with
//   a synchronous 1-cycle read. The read addresses come from the prefetched
//   instruction one cycle before that instruction reaches ID. A small write
//   buffer forwards recent writes. When the operand that was fetched early is
//   not the one ID asks for, reg_stall is raised and the correct address is
//   re-read.
// Ports
//   clk_i  : clock, all flops on the rising edge
//   rst_i  : asynchronous reset, active-high
//   rf     : slave side of ibex_register_file_sram_prefetch_if
//            (prefetch, two read ports, write port, stall flag, stall counter)
// ---------------------------------------------------------------------------
module ibex_register_file_sram_prefetch #(
    parameter bit          RV32E       = 1'b0,
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned BypassDepth = 2,
    parameter int unsigned StallCntW   = 16
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    ibex_register_file_sram_prefetch_if.slave   rf
);

    localparam int unsigned AddrW    = RV32E ? 4 : 5;
    localparam int unsigned NumWords = 2 ** AddrW;
    localparam int unsigned PtrW     = (BypassDepth > 1) ? $clog2(BypassDepth) : 1;
    localparam int          Depth    = int'(BypassDepth);

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_REFETCH = 1'b1
    } state_e;

    // On RV32E bit 4 of the address has no storage behind it.
    function automatic logic [4:0] norm_addr(input logic [4:0] a);
        if (RV32E) begin
            norm_addr = {1'b0, a[3:0]};
        end else begin
            norm_addr = a;
        end
    endfunction

    // x0 always reads zero. On RV32E, so does any address with bit 4 set.
    function automatic logic reads_zero(input logic [4:0] a);
        reads_zero = (a == 5'd0) || (RV32E && a[4]);
    endfunction

    state_e                 state_r;
    logic [4:0]             iss_a_s, iss_b_s;
    logic [4:0]             addr_a_r, addr_b_r;
    logic                   vld_a_r, vld_b_r;
    logic [DataWidth-1:0]   mem_r [NumWords];
    logic [DataWidth-1:0]   sram_a_r, sram_b_r;
    logic [4:0]             waddr_n_s;
    logic                   wr_en_s;
    logic [BypassDepth-1:0] byp_vld_r;
    logic [4:0]             byp_addr_r [BypassDepth];
    logic [DataWidth-1:0]   byp_data_r [BypassDepth];
    logic [PtrW-1:0]        wptr_r;
    logic                   byp_hit_a_s, byp_hit_b_s;
    logic [DataWidth-1:0]   byp_data_a_s, byp_data_b_s;
    logic [DataWidth-1:0]   rdata_a_s, rdata_b_s;
    logic                   miss_a_s, miss_b_s;
    logic                   stall_s;
    logic [StallCntW-1:0]   stall_cnt_r;
    logic                   unused_s;

    // Only the rs1/rs2 fields of the prefetched instruction matter here.
    assign unused_s = ^{rf.pref_instr[31:25], rf.pref_instr[14:0]};

    assign waddr_n_s = norm_addr(rf.waddr);
    assign wr_en_s   = rf.we && (waddr_n_s != 5'd0);

    // Choose the addresses to send to the SRAM this cycle.
    // In RUN, a new instruction uses its rs fields. In REFETCH, ID's own
    // addresses are used. A write always takes port B.
    always_comb begin
        iss_a_s = rf.raddr_a;
        iss_b_s = rf.raddr_b;
        if ((state_r == ST_RUN) && rf.instr_new) begin
            iss_a_s = rf.pref_instr[19:15];
            if (rf.we) begin
                iss_b_s = rf.waddr;
            end else begin
                iss_b_s = rf.pref_instr[24:20];
            end
        end else begin
            iss_a_s = rf.raddr_a;
            if (rf.we) begin
                iss_b_s = rf.waddr;
            end else begin
                iss_b_s = rf.raddr_b;
            end
        end
    end

    // SRAM array write. Port B is used, and the contents are never reset.
    always_ff @(posedge clk_i) begin
        if (wr_en_s) begin
            mem_r[waddr_n_s[AddrW-1:0]] <= rf.wdata;
        end
    end

    // Synchronous SRAM reads. Port B keeps its old data during a write cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sram_a_r <= '0;
            sram_b_r <= '0;
        end else begin
            sram_a_r <= mem_r[iss_a_s[AddrW-1:0]];
            if (!rf.we) begin
                sram_b_r <= mem_r[iss_b_s[AddrW-1:0]];
            end
        end
    end

    // Record which address each SRAM port holds data for. A write on port B
    // leaves that port with nothing usable.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_a_r <= 5'd0;
            addr_b_r <= 5'd0;
            vld_a_r  <= 1'b0;
            vld_b_r  <= 1'b0;
        end else begin
            addr_a_r <= iss_a_s;
            addr_b_r <= iss_b_s;
            vld_a_r  <= 1'b1;
            vld_b_r  <= !rf.we;
        end
    end

    // Circular write-forward buffer. It covers data that the SRAM cannot
    // return yet.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            byp_vld_r <= '0;
            wptr_r    <= '0;
            for (int i = 0; i < Depth; i++) begin
                byp_addr_r[i] <= 5'd0;
                byp_data_r[i] <= '0;
            end
        end else if (wr_en_s) begin
            byp_vld_r[wptr_r]  <= 1'b1;
            byp_addr_r[wptr_r] <= waddr_n_s;
            byp_data_r[wptr_r] <= rf.wdata;
            wptr_r <= (wptr_r == PtrW'(BypassDepth - 1)) ? '0 : wptr_r + 1'b1;
        end
    end

    // Buffer lookup. Entries at or above wptr come from the previous lap and
    // are older. They are scanned first, so later (newer) matches overwrite
    // them.
    always_comb begin
        logic sel_v;
        logic hit_a_v;
        logic hit_b_v;
        sel_v        = 1'b0;
        hit_a_v      = 1'b0;
        hit_b_v      = 1'b0;
        byp_hit_a_s  = 1'b0;
        byp_hit_b_s  = 1'b0;
        byp_data_a_s = '0;
        byp_data_b_s = '0;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < Depth; i++) begin
                sel_v   = (p == 0) ? (PtrW'(i) >= wptr_r) : (PtrW'(i) < wptr_r);
                hit_a_v = sel_v && byp_vld_r[i] && (byp_addr_r[i] == rf.raddr_a);
                hit_b_v = sel_v && byp_vld_r[i] && (byp_addr_r[i] == rf.raddr_b);
                byp_hit_a_s  = byp_hit_a_s | hit_a_v;
                byp_hit_b_s  = byp_hit_b_s | hit_b_v;
                byp_data_a_s = hit_a_v ? byp_data_r[i] : byp_data_a_s;
                byp_data_b_s = hit_b_v ? byp_data_r[i] : byp_data_b_s;
            end
        end
    end

    // Operand A select: zero register, then buffer, then the prefetched SRAM
    // word.
    always_comb begin
        rdata_a_s = sram_a_r;
        miss_a_s  = 1'b0;
        if (reads_zero(rf.raddr_a)) begin
            rdata_a_s = '0;
        end else if (byp_hit_a_s) begin
            rdata_a_s = byp_data_a_s;
        end else if (vld_a_r && (rf.raddr_a == addr_a_r)) begin
            rdata_a_s = sram_a_r;
        end else begin
            miss_a_s  = 1'b1;
        end
    end

    // Operand B select, with the same priority as operand A.
    always_comb begin
        rdata_b_s = sram_b_r;
        miss_b_s  = 1'b0;
        if (reads_zero(rf.raddr_b)) begin
            rdata_b_s = '0;
        end else if (byp_hit_b_s) begin
            rdata_b_s = byp_data_b_s;
        end else if (vld_b_r && (rf.raddr_b == addr_b_r)) begin
            rdata_b_s = sram_b_r;
        end else begin
            miss_b_s  = 1'b1;
        end
    end

    // reset forces the stall low at once, even in the middle of a REFETCH.
    assign stall_s = !rst_i && ((rf.rd_req_a && miss_a_s) || (rf.rd_req_b && miss_b_s));

    // Refetch FSM and saturating stall counter. Any stall (re-)enters REFETCH.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r     <= ST_RUN;
            stall_cnt_r <= '0;
        end else begin
            state_r <= stall_s ? ST_REFETCH : ST_RUN;
            if (stall_s && (stall_cnt_r != {StallCntW{1'b1}})) begin
                stall_cnt_r <= stall_cnt_r + 1'b1;
            end
        end
    end

    assign rf.rdata_a   = rdata_a_s;
    assign rf.rdata_b   = rdata_b_s;
    assign rf.reg_stall = stall_s;
    assign rf.stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_ibex_register_file_sram_prefetch.sv
// ---------------------------------------------------------------------------
// tb_ibex_register_file_sram_prefetch
//   Directed vectors with hand-computed expected values for the SRAM-backed
//   register file. Inputs are applied 1 time unit after the rising edge.
//   Outputs are sampled 1 time unit later.
// ---------------------------------------------------------------------------
module tb_ibex_register_file_sram_prefetch;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    ibex_register_file_sram_prefetch_if #(.DataWidth(32), .StallCntW(16)) rf_if ();

    ibex_register_file_sram_prefetch #(
        .RV32E       (1'b0),
        .DataWidth   (32),
        .BypassDepth (2),
        .StallCntW   (16)
    ) u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .rf    (rf_if.slave)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_idle();
        rf_if.pref_instr = 32'd0;
        rf_if.instr_new  = 1'b0;
        rf_if.rd_req_a   = 1'b0;
        rf_if.raddr_a    = 5'd0;
        rf_if.rd_req_b   = 1'b0;
        rf_if.raddr_b    = 5'd0;
        rf_if.we         = 1'b0;
        rf_if.waddr      = 5'd0;
        rf_if.wdata      = 32'd0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        rf_if.we    = 1'b1;
        rf_if.waddr = a;
        rf_if.wdata = d;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk_instr(input logic [4:0] rs1, input logic [4:0] rs2);
        mk_instr = {7'd0, rs2, rs1, 15'd0};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1);
    end

    initial begin
        // Reset state, with read requests present on both ports
        rst = 1'b1;
        set_idle();
        rf_if.rd_req_a = 1'b1; rf_if.raddr_a = 5'd5;
        rf_if.rd_req_b = 1'b1; rf_if.raddr_b = 5'd9;
        repeat (2) @(posedge clk);
        #2;
        check_eq("rst_rdata_a", rf_if.rdata_a, 32'd0);
        check_eq("rst_rdata_b", rf_if.rdata_b, 32'd0);
        check_eq("rst_stall", 32'(rf_if.reg_stall), 32'd0);
        check_eq("rst_cnt", 32'(rf_if.stall_cnt), 32'd0);
        rst = 1'b0;
        set_idle();
        cyc();

        // Fill x7, x6, x5, wait, then prefetch rs1=5 and read it
        set_idle(); wr(5'd7, 32'h0000_0077); cyc();
        set_idle(); wr(5'd6, 32'h0000_0066); cyc();
        set_idle(); wr(5'd5, 32'hA5A5_0001); cyc();
        set_idle(); repeat (3) cyc();
        set_idle(); rf_if.instr_new = 1'b1; rf_if.pref_instr = mk_instr(5'd5, 5'd0); cyc();
        set_idle(); rf_if.rd_req_a = 1'b1; rf_if.raddr_a = 5'd5; #1;
        check_eq("pref_hit_data", rf_if.rdata_a, 32'hA5A5_0001);
        check_eq("pref_hit_stall", 32'(rf_if.reg_stall), 32'd0);
        cyc();

        // Wrong prediction: prefetch rs1=3, ID reads x7
        set_idle(); rf_if.instr_new = 1'b1; rf_if.pref_instr = mk_instr(5'd3, 5'd0); cyc();
        set_idle(); rf_if.rd_req_a = 1'b1; rf_if.raddr_a = 5'd7; #1;
        check_eq("mispred_stall", 32'(rf_if.reg_stall), 32'd1);
        cyc();
        #1;
        check_eq("refetch_stall", 32'(rf_if.reg_stall), 32'd0);
        check_eq("refetch_data", rf_if.rdata_a, 32'h0000_0077);
        check_eq("refetch_cnt", 32'(rf_if.stall_cnt), 32'd1);
        cyc();

        // Write x9 then read it on both ports the next cycle (buffer path)
        set_idle(); wr(5'd9, 32'h0000_0099); cyc();
        set_idle();
        rf_if.rd_req_a = 1'b1; rf_if.raddr_a = 5'd9;
        rf_if.rd_req_b = 1'b1; rf_if.raddr_b = 5'd9; #1;
        check_eq("byp_a", rf_if.rdata_a, 32'h0000_0099);
        check_eq("byp_b", rf_if.rdata_b, 32'h0000_0099);
        check_eq("byp_stall", 32'(rf_if.reg_stall), 32'd0);
        cyc();

        // x1, x2, x3 back to back. x1 has left the buffer and comes from the SRAM.
        set_idle(); wr(5'd1, 32'h0000_0011); cyc();
        set_idle(); wr(5'd2, 32'h0000_0022); cyc();
        set_idle(); wr(5'd3, 32'h0000_0033);
        rf_if.instr_new = 1'b1; rf_if.pref_instr = mk_instr(5'd1, 5'd3); cyc();
        set_idle();
        rf_if.rd_req_a = 1'b1; rf_if.raddr_a = 5'd1;
        rf_if.rd_req_b = 1'b1; rf_if.raddr_b = 5'd3; #1;
        check_eq("evict_sram_a", rf_if.rdata_a, 32'h0000_0011);
        check_eq("evict_byp_b", rf_if.rdata_b, 32'h0000_0033);
        check_eq("evict_stall", 32'(rf_if.reg_stall), 32'd0);
        cyc();

        // Two writes to x4: a same-cycle write is not forwarded; the newer entry wins
        set_idle(); wr(5'd4, 32'h0000_0001); cyc();
        set_idle(); wr(5'd4, 32'h0000_0002);
        rf_if.rd_req_a = 1'b1; rf_if.raddr_a = 5'd4; #1;
        check_eq("samecyc_old", rf_if.rdata_a, 32'h0000_0001);
        check_eq("samecyc_stall", 32'(rf_if.reg_stall), 32'd0);
        cyc();
        set_idle(); rf_if.rd_req_a = 1'b1; rf_if.raddr_a = 5'd4; #1;
        check_eq("newest_wins", rf_if.rdata_a, 32'h0000_0002);
        cyc();

        // A write to x0 is dropped and x0 reads zero
        set_idle(); wr(5'd0, 32'h0000_00FF); cyc();
        set_idle();
        rf_if.rd_req_a = 1'b1; rf_if.raddr_a = 5'd0;
        rf_if.rd_req_b = 1'b1; rf_if.raddr_b = 5'd0; #1;
        check_eq("x0_a", rf_if.rdata_a, 32'd0);
        check_eq("x0_b", rf_if.rdata_b, 32'd0);
        check_eq("x0_stall", 32'(rf_if.reg_stall), 32'd0);
        check_eq("x0_cnt", 32'(rf_if.stall_cnt), 32'd1);
        cyc();

        // Port-B write conflicts: reset, prefetch x6 on B, then 4 write cycles
        rst = 1'b1; #2; rst = 1'b0;
        set_idle(); rf_if.raddr_b = 5'd6; cyc();
        for (int i = 0; i < 4; i++) begin
            set_idle();
            wr(5'(10 + i), 32'h0000_0100 + 32'(i));
            rf_if.rd_req_b = 1'b1; rf_if.raddr_b = 5'd6; #1;
            check_eq("wconf_stall", 32'(rf_if.reg_stall), (i == 0) ? 32'd0 : 32'd1);
            if (i == 0) begin
                check_eq("wconf_first_data", rf_if.rdata_b, 32'h0000_0066);
            end
            cyc();
        end
        set_idle(); rf_if.rd_req_b = 1'b1; rf_if.raddr_b = 5'd6; #1;
        check_eq("wconf_tail_stall", 32'(rf_if.reg_stall), 32'd1);
        cyc();
        #1;
        check_eq("wconf_done_stall", 32'(rf_if.reg_stall), 32'd0);
        check_eq("wconf_done_data", rf_if.rdata_b, 32'h0000_0066);
        check_eq("wconf_cnt", 32'(rf_if.stall_cnt), 32'd4);
        cyc();

        // Reset asserted while in REFETCH with a further miss pending
        set_idle(); rf_if.rd_req_a = 1'b1; rf_if.raddr_a = 5'd7; #1;
        check_eq("pre_rst_stall", 32'(rf_if.reg_stall), 32'd1);
        check_eq("pre_rst_cnt", 32'(rf_if.stall_cnt), 32'd4);
        cyc();
        rf_if.raddr_a = 5'd8; #1;
        check_eq("refetch_miss_stall", 32'(rf_if.reg_stall), 32'd1);
        check_eq("refetch_miss_cnt", 32'(rf_if.stall_cnt), 32'd5);
        rst = 1'b1; #1;
        check_eq("midrst_stall", 32'(rf_if.reg_stall), 32'd0);
        check_eq("midrst_cnt", 32'(rf_if.stall_cnt), 32'd0);
        cyc();
        rst = 1'b0;
        set_idle();
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
